// File: rtl/breakout_pkg.sv
// Shared constants for the breakout design: game-state encodings, screen size,
// RGB565 colours, brick-wall geometry defaults and the collision-scan state type.
package breakout_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_WIN  = 2'b10;
    localparam logic [1:0] ST_LOSE = 2'b11;

    localparam int H_VALID = 640;
    localparam int V_VALID = 480;

    localparam logic [15:0] RGB_BLACK  = 16'h0000;
    localparam logic [15:0] RGB_RED    = 16'hF800;
    localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
    localparam logic [15:0] RGB_WHITE  = 16'hFFFF;

    localparam int BALL_RADIUS_DEF = 5;
    localparam int BRICK_TOP_DEF   = 40;
    localparam int BRICK_W_DEF     = 64;
    localparam int BRICK_H_DEF     = 16;
    localparam int BRICK_GAP_DEF   = 1;

    localparam int NUM_BRICKS = 50;
    localparam int ROWS       = 5;
    localparam int COLS       = 10;

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_RUN,
        SCAN_HIT
    } scan_state_e;

endpackage

// File: rtl/brick_hit_test.sv
// Combinational test of one brick cell against the ball centre, using the
// brick rectangle grown by the ball radius on every side.
module brick_hit_test
    import breakout_pkg::*;
#(
    parameter int BALL_RADIUS = BALL_RADIUS_DEF,
    parameter int BRICK_TOP   = BRICK_TOP_DEF,
    parameter int BRICK_W     = BRICK_W_DEF,
    parameter int BRICK_H     = BRICK_H_DEF,
    parameter int BRICK_GAP   = BRICK_GAP_DEF
) (
    input  logic [2:0] i_row,
    input  logic [3:0] i_col,
    input  logic [9:0] i_sx,
    input  logic [9:0] i_sy,
    output logic       o_hit
);

    logic [10:0] w_x0, w_x1, w_y0, w_y1;
    logic [10:0] w_sx, w_sy, w_rad;

    // 11 bits keeps ball+radius and edge+radius free of wrap for any 10-bit input.
    assign w_rad = 11'(BALL_RADIUS);
    assign w_sx  = 11'(i_sx);
    assign w_sy  = 11'(i_sy);
    assign w_x0  = 11'(i_col) * 11'(BRICK_W) + 11'(BRICK_GAP);
    assign w_x1  = (11'(i_col) + 11'd1) * 11'(BRICK_W) - 11'd1 - 11'(BRICK_GAP);
    assign w_y0  = 11'(BRICK_TOP) + 11'(i_row) * 11'(BRICK_H) + 11'(BRICK_GAP);
    assign w_y1  = 11'(BRICK_TOP) + (11'(i_row) + 11'd1) * 11'(BRICK_H) - 11'd1 - 11'(BRICK_GAP);

    assign o_hit = (w_sx + w_rad >= w_x0) && (w_sx <= w_x1 + w_rad) &&
                   (w_sy + w_rad >= w_y0) && (w_sy <= w_y1 + w_rad);

endmodule

// File: rtl/brick_field_ctrl.sv
// 5x10 brick wall: alive mask, one-brick-per-clock collision scan, hit count,
// win flag and brick pixel colour. Define BRICK_HARD_ROW_EN for two-hit row 0.
module brick_field_ctrl
    import breakout_pkg::*;
#(
    parameter int          BALL_RADIUS = BALL_RADIUS_DEF,
    parameter int          BRICK_TOP   = BRICK_TOP_DEF,
    parameter int          BRICK_W     = BRICK_W_DEF,
    parameter int          BRICK_H     = BRICK_H_DEF,
    parameter int          BRICK_GAP   = BRICK_GAP_DEF,
    parameter logic [15:0] BRICK_COLOR = RGB_RED,
    parameter logic [15:0] HARD_COLOR  = RGB_YELLOW
) (
    input  logic        i_vga_clk,
    input  logic        i_sys_rst,
    input  logic [1:0]  i_game_state,
    input  logic        i_game_reset,
    input  logic [9:0]  i_ball_x,
    input  logic [9:0]  i_ball_y,
    input  logic [9:0]  i_pix_x,
    input  logic [9:0]  i_pix_y,
    output logic [49:0] o_brick_collision,
    output logic [49:0] o_brick_alive,
    output logic [5:0]  o_hit_count,
    output logic        o_win_sig,
    output logic [15:0] o_pix_data
);

    scan_state_e r_state, w_next;
    logic [9:0]  r_ball_x_q, r_ball_y_q, r_sx, r_sy;
    logic [2:0]  r_row;
    logic [3:0]  r_col;
    logic [5:0]  r_k;
    logic        r_pending;
    logic [49:0] r_alive, r_collision;
    logic [5:0]  r_hit_count;
    logic        r_win;
`ifdef BRICK_HARD_ROW_EN
    logic [9:0]  r_hard;
`endif

    logic w_play, w_move, w_hit, w_take;

    assign w_play = (i_game_state == ST_PLAY);
    assign w_move = (i_ball_x != r_ball_x_q) || (i_ball_y != r_ball_y_q);
    assign w_take = (r_state == SCAN_RUN) && w_play && w_hit && r_alive[r_k];

    brick_hit_test #(
        .BALL_RADIUS (BALL_RADIUS),
        .BRICK_TOP   (BRICK_TOP),
        .BRICK_W     (BRICK_W),
        .BRICK_H     (BRICK_H),
        .BRICK_GAP   (BRICK_GAP)
    ) u_hit_test (
        .i_row (r_row),
        .i_col (r_col),
        .i_sx  (r_sx),
        .i_sy  (r_sy),
        .o_hit (w_hit)
    );

    always_ff @(posedge i_vga_clk or posedge i_sys_rst) begin
        if (i_sys_rst) r_state <= SCAN_IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SCAN_IDLE: if ((w_move || r_pending) && w_play) w_next = SCAN_RUN;
            SCAN_RUN: begin
                if (!w_play)                            w_next = SCAN_IDLE;
                else if (w_take)                        w_next = SCAN_HIT;
                else if (r_k == 6'(NUM_BRICKS - 1))     w_next = SCAN_IDLE;
            end
            SCAN_HIT:  w_next = SCAN_IDLE;
            default:   w_next = SCAN_IDLE;
        endcase
        if (i_game_reset) w_next = SCAN_IDLE;
    end

    // The collision pulse and the alive/count update share the edge that leaves SCAN
    // for HIT, so a game_reset sampled on that edge suppresses the whole hit.
    always_ff @(posedge i_vga_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_ball_x_q  <= '0;
            r_ball_y_q  <= '0;
            r_sx        <= '0;
            r_sy        <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_k         <= '0;
            r_pending   <= 1'b0;
            r_alive     <= '1;
            r_collision <= '0;
            r_hit_count <= '0;
            r_win       <= 1'b0;
`ifdef BRICK_HARD_ROW_EN
            r_hard      <= '1;
`endif
        end else begin
            r_ball_x_q  <= i_ball_x;
            r_ball_y_q  <= i_ball_y;
            r_collision <= '0;
            if (i_game_reset) begin
                r_alive     <= '1;
                r_hit_count <= '0;
                r_pending   <= 1'b0;
                r_win       <= 1'b0;
`ifdef BRICK_HARD_ROW_EN
                r_hard      <= '1;
`endif
            end else begin
                r_win <= (r_alive == '0);
                if (r_state == SCAN_IDLE && w_next == SCAN_RUN) begin
                    r_pending <= 1'b0;
                    r_row     <= '0;
                    r_col     <= '0;
                    r_k       <= '0;
                    r_sx      <= i_ball_x;
                    r_sy      <= i_ball_y;
                end else if (r_state == SCAN_RUN && !w_play) begin
                    r_pending <= 1'b0;
                end else if (r_state != SCAN_IDLE && w_move) begin
                    r_pending <= 1'b1;
                end

                if (r_state == SCAN_RUN && w_next == SCAN_RUN) begin
                    r_k <= r_k + 6'd1;
                    if (r_col == 4'(COLS - 1)) begin
                        r_col <= '0;
                        r_row <= r_row + 3'd1;
                    end else begin
                        r_col <= r_col + 4'd1;
                    end
                end

                if (w_take) begin
                    r_collision <= 50'd1 << r_k;
`ifdef BRICK_HARD_ROW_EN
                    if (r_k < 6'(COLS) && r_hard[r_k[3:0]]) begin
                        r_hard[r_k[3:0]] <= 1'b0;
                    end else begin
                        r_alive[r_k] <= 1'b0;
                        if (r_hit_count < 6'(NUM_BRICKS)) r_hit_count <= r_hit_count + 6'd1;
                    end
`else
                    r_alive[r_k] <= 1'b0;
                    if (r_hit_count < 6'(NUM_BRICKS)) r_hit_count <= r_hit_count + 6'd1;
`endif
                end
            end
        end
    end

    logic [10:0] w_rel_y;
    logic [2:0]  w_pix_row;
    logic [3:0]  w_pix_col;
    logic [5:0]  w_pix_k;
    logic        w_in_rows, w_in_cols, w_in_inset, w_hard_px;

    assign w_rel_y    = 11'(i_pix_y) - 11'(BRICK_TOP);
    assign w_in_rows  = (11'(i_pix_y) >= 11'(BRICK_TOP)) && (w_rel_y < 11'(ROWS * BRICK_H));
    assign w_pix_row  = w_rel_y[6:4];
    assign w_pix_col  = i_pix_x[9:6];
    assign w_in_cols  = (w_pix_col < 4'(COLS));
    assign w_in_inset = (i_pix_x[5:0] >= 6'(BRICK_GAP)) && (i_pix_x[5:0] <= 6'(BRICK_W - 1 - BRICK_GAP)) &&
                        (w_rel_y[3:0] >= 4'(BRICK_GAP)) && (w_rel_y[3:0] <= 4'(BRICK_H - 1 - BRICK_GAP));
    assign w_pix_k    = 6'(w_pix_row) * 6'(COLS) + 6'(w_pix_col);
`ifdef BRICK_HARD_ROW_EN
    assign w_hard_px  = (w_pix_row == 3'd0) && r_hard[w_pix_col];
`else
    assign w_hard_px  = 1'b0;
`endif

    always_comb begin
        o_pix_data = RGB_BLACK;
        if (w_play && w_in_rows && w_in_cols && w_in_inset && r_alive[w_pix_k])
            o_pix_data = w_hard_px ? HARD_COLOR : BRICK_COLOR;
    end

    assign o_brick_collision = r_collision;
    assign o_brick_alive     = r_alive;
    assign o_hit_count       = r_hit_count;
    assign o_win_sig         = r_win;

endmodule

// File: tb/tb_brick_field_ctrl.sv
// Bench for brick_field_ctrl: stimulus queues expected collision pulses, a
// negedge monitor pops and compares them whenever the DUT pulses.
module tb_brick_field_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  gameState;
    logic        gameReset;
    logic [9:0]  ballX, ballY, pixX, pixY;
    logic [49:0] brickCollision, brickAlive;
    logic [5:0]  hitCount;
    logic        winSig;
    logic [15:0] pixData;

    brick_field_ctrl dut (
        .i_vga_clk         (clk),
        .i_sys_rst         (rst),
        .i_game_state      (gameState),
        .i_game_reset      (gameReset),
        .i_ball_x          (ballX),
        .i_ball_y          (ballY),
        .i_pix_x           (pixX),
        .i_pix_y           (pixY),
        .o_brick_collision (brickCollision),
        .o_brick_alive     (brickAlive),
        .o_hit_count       (hitCount),
        .o_win_sig         (winSig),
        .o_pix_data        (pixData)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cycle;
        int bitIdx;
    } exp_t;

    exp_t        expQ[$];
    exp_t        popped;
    logic [49:0] oneHot;
    int          nChecks = 0;
    int          nPass   = 0;

    localparam logic [49:0] ALL = {50{1'b1}};

    // Every nonzero collision sample must match the oldest queued pulse, bit and cycle.
    always @(negedge clk) begin
        if (!rst && brickCollision !== 50'd0) begin
            nChecks++;
            if (expQ.size() == 0) begin
                $display("[TB] FAIL unexpected_pulse: got %0h at cycle %0d, expected none", brickCollision, cyc);
            end else begin
                popped = expQ.pop_front();
                oneHot = 50'd1 << popped.bitIdx;
                if (brickCollision === oneHot && cyc == popped.cycle)
                    nPass++;
                else
                    $display("[TB] FAIL pulse: got %0h at cycle %0d, expected %0h at cycle %0d",
                             brickCollision, cyc, oneHot, popped.cycle);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int x, input int y, output int t);
        @(posedge clk);
        #1;
        ballX = 10'(x);
        ballY = 10'(y);
        t = cyc;
    endtask

    task automatic pulseGameReset();
        @(posedge clk);
        #1;
        gameReset = 1'b1;
        @(posedge clk);
        #1;
        gameReset = 1'b0;
    endtask

    task automatic checkPix(input string name, input int x, input int y, input logic [15:0] exp);
        pixX = 10'(x);
        pixY = 10'(y);
        #1;
        checkOutput(name, 64'(pixData), 64'(exp));
    endtask

    initial begin
        int t;
        int t0;
        rst       = 1'b1;
        gameState = 2'b01;
        gameReset = 1'b0;
        ballX     = 10'd320;
        ballY     = 10'd240;
        pixX      = '0;
        pixY      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset_alive", 64'(brickAlive), 64'(ALL));
        checkOutput("reset_count", 64'(hitCount), 64'd0);
        checkOutput("reset_win", 64'(winSig), 64'd0);
        checkOutput("reset_collision", 64'(brickCollision), 64'd0);

        // Parked ball in the open field: nothing may be hit.
        waitCycles(100);
        checkOutput("park_alive", 64'(brickAlive), 64'(ALL));
        checkPix("pix_brick0", 10, 45, 16'hF800);
        checkPix("pix_corner_tl", 1, 41, 16'hF800);
        checkPix("pix_corner_br", 62, 54, 16'hF800);
        checkPix("pix_gap_left", 0, 45, 16'h0000);
        checkPix("pix_gap_right", 63, 45, 16'h0000);
        checkPix("pix_gap_top", 10, 40, 16'h0000);
        checkPix("pix_above", 10, 39, 16'h0000);
        checkPix("pix_row4_last", 10, 118, 16'hF800);
        checkPix("pix_below", 10, 120, 16'h0000);
        checkPix("pix_col9", 630, 45, 16'hF800);
        checkPix("pix_col10", 650, 45, 16'h0000);

        // Approach brick 0 from above: 35 misses, 36 touches.
        applyStimulus(30, 35, t);
        waitCycles(60);
        applyStimulus(30, 36, t);
        expQ.push_back('{t + 2, 0});
        waitCycles(60);
        checkOutput("b0_drained", 64'(expQ.size()), 64'd0);
        checkOutput("b0_alive", 64'(brickAlive), 64'(ALL & ~50'd1));
        checkOutput("b0_count", 64'(hitCount), 64'd1);
        checkPix("b0_pix_gone", 10, 45, 16'h0000);

        applyStimulus(220, 90, t);
        expQ.push_back('{t + 25, 23});
        waitCycles(60);
        checkOutput("b23_drained", 64'(expQ.size()), 64'd0);
        checkOutput("b23_alive", 64'(brickAlive), 64'(ALL & ~50'd1 & ~(50'd1 << 23)));
        checkOutput("b23_count", 64'(hitCount), 64'd2);
        checkPix("b23_pix_gone", 200, 80, 16'h0000);
        checkPix("b24_pix", 260, 80, 16'hF800);

        pulseGameReset();
        checkOutput("greset_alive", 64'(brickAlive), 64'(ALL));
        checkOutput("greset_count", 64'(hitCount), 64'd0);

        // Straddling bricks 0 and 1: lowest index wins, then the neighbour.
        applyStimulus(64, 58, t);
        expQ.push_back('{t + 2, 0});
        waitCycles(60);
        applyStimulus(64, 57, t);
        expQ.push_back('{t + 3, 1});
        waitCycles(60);
        checkOutput("tie_drained", 64'(expQ.size()), 64'd0);
        checkOutput("tie_count", 64'(hitCount), 64'd2);

        // game_reset on the edge that would launch brick 23's pulse.
        applyStimulus(320, 240, t);
        waitCycles(60);
        applyStimulus(220, 90, t);
        waitCycles(24);
        gameReset = 1'b1;
        waitCycles(1);
        gameReset = 1'b0;
        checkOutput("race_alive", 64'(brickAlive), 64'(ALL));
        checkOutput("race_count", 64'(hitCount), 64'd0);
        waitCycles(60);
        checkOutput("race_drained", 64'(expQ.size()), 64'd0);

        // Leaving PLAY mid-scan aborts without a pulse or a later rescan.
        applyStimulus(320, 240, t);
        waitCycles(60);
        applyStimulus(220, 90, t);
        waitCycles(5);
        gameState = 2'b00;
        checkPix("nonplay_pix", 10, 45, 16'h0000);
        waitCycles(3);
        gameState = 2'b01;
        waitCycles(60);
        checkOutput("abort_alive", 64'(brickAlive), 64'(ALL));
        checkOutput("abort_count", 64'(hitCount), 64'd0);
        checkPix("play_pix_back", 10, 45, 16'hF800);

        // A move during a scan queues exactly one rescan at the new position.
        applyStimulus(320, 200, t0);
        waitCycles(1);
        applyStimulus(30, 36, t);
        expQ.push_back('{t0 + 53, 0});
        waitCycles(100);
        checkOutput("pending_drained", 64'(expQ.size()), 64'd0);
        checkOutput("pending_count", 64'(hitCount), 64'd1);
        checkOutput("pending_alive", 64'(brickAlive), 64'(ALL & ~50'd1));

        // Clear the wall by visiting every brick centre in row-major order.
        pulseGameReset();
        for (int k = 0; k < 50; k++) begin
            applyStimulus((k % 10) * 64 + 32, 48 + (k / 10) * 16, t);
            expQ.push_back('{t + 2 + k, k});
            if (k < 49) begin
                waitCycles(55);
                if (k == 24) checkOutput("half_count", 64'(hitCount), 64'd25);
            end else begin
                waitCycles(51);
                checkOutput("last_alive", 64'(brickAlive), 64'd0);
                checkOutput("win_not_yet", 64'(winSig), 64'd0);
                waitCycles(1);
                checkOutput("win_set", 64'(winSig), 64'd1);
                checkOutput("full_count", 64'(hitCount), 64'd50);
            end
        end
        waitCycles(10);
        checkOutput("win_holds", 64'(winSig), 64'd1);
        checkOutput("wall_drained", 64'(expQ.size()), 64'd0);

        pulseGameReset();
        checkOutput("final_win", 64'(winSig), 64'd0);
        checkOutput("final_alive", 64'(brickAlive), 64'(ALL));
        checkOutput("final_count", 64'(hitCount), 64'd0);
        checkPix("final_pix", 10, 45, 16'hF800);
        waitCycles(20);
        checkOutput("end_drained", 64'(expQ.size()), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/brick_field_ctrl.md
Name: brick_field_ctrl

Overview:
- Owns the 5x10 brick wall: 50 alive bits, ball-versus-brick collision detection, brick pixel colour, hit count and win detection.
- Sits directly upstream of the ball/racket mover:
  - consumes the mover's ball_x / ball_y;
  - produces the one-hot brick_collision vector that the mover uses to flip vertical direction.
- Brick pixels go to the top-level pixel mux alongside the mover's pixel output.
- Collision is found by a sequential scan, one brick per clock, started whenever the ball's integer position changes.

Parameters:
- BALL_RADIUS, 5, ball radius in px; must match the mover.
- BRICK_TOP, 40, y of the top edge of row 0.
- BRICK_W, 64, column pitch in px (10 columns span 640).
- BRICK_H, 16, row pitch in px.
- BRICK_GAP, 1, inset on every side of each brick cell; drawn brick is (BRICK_W-2*GAP) x (BRICK_H-2*GAP).
- BRICK_COLOR, 16'hF800, RGB565 colour of a normal brick.
- HARD_COLOR, 16'hFFE0, RGB565 colour of an unhit hard brick (feature only).

Ports:
- vga_clk  in  1  pixel clock; sole clock.
- sys_rst  in  1  asynchronous, active-high reset.
- game_state  in  2  2'b01 = PLAY; any other value = non-play.
- game_reset  in  1  synchronous level; restores the full wall.
- ball_x  in  10  ball centre x (integer px), from the mover.
- ball_y  in  10  ball centre y.
- pix_x  in  10  current scan pixel x.
- pix_y  in  10  current scan pixel y.
- brick_collision  out  50  one-hot, one-cycle pulse; bit k = brick k hit.
- brick_alive  out  50  alive mask; bit k = row*10+col.
- hit_count  out  6  bricks destroyed, 0..50.
- win_sig  out  1  high while all bricks are destroyed.
- pix_data  out  16  brick colour at (pix_x,pix_y), else 16'h0000.

Behaviour:
- Reset values: brick_alive = all ones; brick_collision = 0; hit_count = 0; win_sig = 0; FSM = IDLE; pending = 0; ball_x_q/ball_y_q = 0.
- Geometry for brick k (row r = 0..4, col c = 0..9):
  - x0 = c*BRICK_W + GAP, x1 = (c+1)*BRICK_W - 1 - GAP
  - y0 = BRICK_TOP + r*BRICK_H + GAP, y1 = BRICK_TOP + (r+1)*BRICK_H - 1 - GAP
- Hit test (AABB expanded by the radius): ball_x + R >= x0 && ball_x <= x1 + R && ball_y + R >= y0 && ball_y <= y1 + R.
  - Evaluate in 11-bit unsigned arithmetic; no wrap.
- Change detect: ball_x_q/ball_y_q register the inputs every cycle. move = (ball_x != ball_x_q) || (ball_y != ball_y_q).
- FSM:
  - IDLE: go to SCAN when (move || pending) and game_state == PLAY.
    - On entry: clear pending; clear the r/c/k counters; latch the scan position (sx,sy) from ball_x/ball_y.
  - SCAN: test brick k against (sx,sy), one brick per cycle, k = 0..49 in row-major order.
    - Alive and overlapping: go to HIT, holding k.
    - k == 49 with no hit: return to IDLE.
  - HIT: one cycle.
    - Assert brick_collision[k] = 1 (registered output, so it is visible the cycle after the SCAN test).
    - Clear brick_alive[k] on the same edge.
    - hit_count += 1.
    - Return to IDLE.
  - At most one hit per scan; ties resolve to the lowest k.
- Latency: move seen at cycle t -> brick k tested at cycle t+1+k -> pulse during cycle t+2+k. Worst case 52 cycles, well inside one ball-move period.
- move asserted while in SCAN or HIT sets pending; exactly one rescan follows.
- game_state leaves PLAY during SCAN: abort to IDLE, no pulse, pending cleared.
- game_reset (priority over everything except sys_rst):
  - alive = all ones; hit_count = 0; collision = 0; pending = 0; FSM = IDLE.
  - game_reset coinciding with HIT: reset wins, no pulse.
- win_sig: registered (brick_alive == 0). Stays high until game_reset.
- hit_count saturates at 50.
- pix_data (combinational):
  - col = pix_x[9:6]; row = (pix_y - BRICK_TOP) >> 4.
  - Inside rows 0..4, inside the GAP inset, and alive: BRICK_COLOR. Otherwise 0.
  - Output is 0 regardless of position when game_state != PLAY.

Optional Feature:
- BRICK_HARD_ROW_EN defined:
  - Row 0 (k = 0..9) bricks need two hits; a 10-bit hard mask resets to all ones.
  - First hit: pulse brick_collision[k] and clear hard[k]; brick_alive[k] stays 1 and hit_count is unchanged.
  - Second hit: normal destroy.
  - Rendering: row 0 drawn HARD_COLOR while hard[k] = 1.
  - game_reset also restores the hard mask.
- Undefined: every brick dies on its first hit; no hard mask logic.

Decomposition:
- Package breakout_pkg:
  - game-state encodings (ST_PLAY = 2'b01, etc.);
  - H_VALID = 640, V_VALID = 480;
  - RGB565 colour constants;
  - brick geometry constants;
  - NUM_BRICKS = 50, ROWS = 5, COLS = 10.
- Sub-module brick_hit_test: combinational AABB test of one brick (r, c, sx, sy) -> hit. Instantiated once in the scan datapath.

Test Plan:
- Reset, PLAY, ball parked at (320,240) for 100 cycles -> brick_alive = all ones, brick_collision never nonzero, pix_data at (10,45) = 16'hF800.
- Ball steps (30,60) -> (30,58) -> exactly one pulse on bit 0, exactly 2 cycles after the change; brick_alive[0] = 0; hit_count = 1; pix_data at (10,45) = 0.
- Ball moves to (220,90) -> brick 23 (x 193..254, y 73..86) hit; pulse 25 cycles after the change; hit_count increments.
- Ball moves to (64,58), overlapping bricks 0 and 1 with both alive -> only bit 0 pulses. Next move to (64,57) -> bit 1 pulses.
- Assert game_reset on the HIT cycle -> no pulse; mask all ones; hit_count = 0.
  - game_state = 2'b00 mid-scan -> scan aborted, no pulse.
- Destroy all 50 bricks -> win_sig = 1 one cycle after the last clear; hit_count = 50.
  - BRICK_HARD_ROW_EN: brick 0 needs 2 pulses to clear; colour changes 16'hFFE0 -> 16'hF800 -> 0.
